// File: rtl/ept_in_fanout.sv
// Fans one library word stream out to N per-module FIFOs by destination address.
// Optional macro EPT_IN_BROADCAST_EN: address 3'b111 is pushed to every FIFO at once.
module ept_in_fanout #(
  parameter int N     = 1,
  parameter int DEPTH = 4
) (
  input  logic              aclk,
  input  logic              reset_n,
  input  logic [22:0]       uc_in,
  input  logic              uc_in_valid,
  output logic              uc_in_ready,
  output logic [N*23-1:0]   uc_in_m,
  output logic [N-1:0]      uc_in_m_valid,
  input  logic [N-1:0]      uc_in_m_ready,
  output logic [7:0]        drop_cnt
);

  // Handshake: a word moves on a rising edge where its valid and ready are both 1;
  // a source holds data and valid until that edge, ready never waits on valid.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [3:0]    N_W      = 4'(N);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [2:0]   addr;
  logic         is_bcast;
  logic         is_mapped;
  logic         tgt_full;
  logic         ready_raw;
  logic         accept;
  logic         drop;
  logic [N-1:0] full;
  logic [N-1:0] empty;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic [7:0]   drop_cnt_q;
  logic [7:0]   drop_cnt_d;

  assign addr = uc_in[22:20];

`ifdef EPT_IN_BROADCAST_EN
  assign is_bcast = (addr == 3'd7);
`else
  assign is_bcast = 1'b0;
`endif

  assign is_mapped = ~is_bcast & ({1'b0, addr} < N_W);

  // Ready looks only at current fullness, so a pop in the same cycle never frees a slot early.
  always_comb begin
    tgt_full  = 1'b0;
    ready_raw = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (addr == 3'(i) && full[i]) tgt_full = 1'b1;
    end
    if (is_bcast)       ready_raw = ~|full;
    else if (is_mapped) ready_raw = ~tgt_full;
  end

  assign uc_in_ready = reset_n & ready_raw;
  assign accept      = uc_in_valid & uc_in_ready;
  assign drop        = accept & ~is_bcast & ~is_mapped;

  always_comb begin
    push = '0;
    for (int i = 0; i < N; i++) begin
      push[i] = accept & (is_bcast | (is_mapped & (addr == 3'(i))));
    end
  end

  assign drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= 8'd0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar g = 0; g < N; g++) begin : g_fifo
    logic [22:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] wr_d;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign full[g]  = (cnt_q == FULL_CNT);
    assign empty[g] = (cnt_q == '0);
    assign pop[g]   = ~empty[g] & uc_in_m_ready[g];

    always_comb begin
      wr_d  = push[g] ? wr_q + AW'(1) : wr_q;
      rd_d  = pop[g]  ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q;
      if (push[g] && !pop[g])      cnt_d = cnt_q + CW'(1);
      else if (!push[g] && pop[g]) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge aclk or negedge reset_n) begin
      if (!reset_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge aclk) begin
      if (push[g]) mem_q[wr_q] <= uc_in;
    end

    assign uc_in_m[g*23 +: 23] = empty[g] ? 23'd0 : mem_q[rd_q];
    assign uc_in_m_valid[g]    = ~empty[g];
  end

endmodule

// File: tb/tb_ept_in_fanout.sv
// Bench for ept_in_fanout (N=4, DEPTH=4): vector table, directed corner sequences and
// random traffic against a queue-based model; define EPT_IN_BROADCAST_EN to add broadcast.
module tb_ept_in_fanout;

  localparam int NP = 4;
  localparam int DP = 4;

  logic              aclk;
  logic              reset_n;
  logic [22:0]       uc_in;
  logic              uc_in_valid;
  logic              uc_in_ready;
  logic [NP*23-1:0]  uc_in_m;
  logic [NP-1:0]     uc_in_m_valid;
  logic [NP-1:0]     uc_in_m_ready;
  logic [7:0]        drop_cnt;

  ept_in_fanout #(.N(NP), .DEPTH(DP)) dut (
    .aclk          (aclk),
    .reset_n       (reset_n),
    .uc_in         (uc_in),
    .uc_in_valid   (uc_in_valid),
    .uc_in_ready   (uc_in_ready),
    .uc_in_m       (uc_in_m),
    .uc_in_m_valid (uc_in_m_valid),
    .uc_in_m_ready (uc_in_m_ready),
    .drop_cnt      (drop_cnt)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [22:0] exp_q [NP][$];
  int          exp_drop;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Compares outputs with the model for the current inputs, then advances the model
  // by what the coming rising edge does.
  task automatic model_step();
    int          a;
    logic        bc;
    logic        er;
    logic        ev;
    logic [22:0] es;
    a  = int'(uc_in[22:20]);
    bc = 1'b0;
`ifdef EPT_IN_BROADCAST_EN
    bc = (a == 7);
`endif
    er = 1'b1;
    if (bc) begin
      for (int i = 0; i < NP; i++) if (exp_q[i].size() >= DP) er = 1'b0;
    end else if (a < NP) begin
      er = (exp_q[a].size() < DP);
    end
    chk("uc_in_ready", 96'(uc_in_ready), 96'(er));
    for (int i = 0; i < NP; i++) begin
      ev = (exp_q[i].size() > 0);
      es = ev ? exp_q[i][0] : 23'd0;
      chk($sformatf("m_valid[%0d]", i), 96'(uc_in_m_valid[i]), 96'(ev));
      chk($sformatf("m_data[%0d]", i), 96'(uc_in_m[i*23 +: 23]), 96'(es));
    end
    chk("drop_cnt", 96'(drop_cnt), 96'(exp_drop));
    for (int i = 0; i < NP; i++) begin
      if (exp_q[i].size() > 0 && uc_in_m_ready[i]) void'(exp_q[i].pop_front());
    end
    if (uc_in_valid && er) begin
      if (bc) begin
        for (int i = 0; i < NP; i++) exp_q[i].push_back(uc_in);
      end else if (a < NP) begin
        exp_q[a].push_back(uc_in);
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  endtask

  // driver
  task automatic drive_cycle(input logic [22:0] w, input logic v, input logic [NP-1:0] mr);
    @(negedge aclk);
    uc_in         = w;
    uc_in_valid   = v;
    uc_in_m_ready = mr;
    #1;
    model_step();
  endtask

  typedef struct {
    logic [22:0]      w;
    logic             v;
    logic [NP-1:0]    mr;
    logic             exp_rdy;
    logic [NP-1:0]    exp_vld;
    logic [NP*23-1:0] exp_m;
    logic [7:0]       exp_drop;
  } vec_t;

  vec_t        tbl [6];
  logic [22:0] got [$];
  logic [22:0] bw;
  int          npop;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_drop = 0;
    reset_n       = 1'b0;
    uc_in         = 23'd0;
    uc_in_valid   = 1'b0;
    uc_in_m_ready = '0;

    tbl[0] = '{23'h000001, 1'b1, 4'b0000, 1'b1, 4'b0000, 92'd0, 8'd0};
    tbl[1] = '{23'h100002, 1'b1, 4'b0000, 1'b1, 4'b0001,
               {23'd0, 23'd0, 23'd0, 23'h000001}, 8'd0};
    tbl[2] = '{23'h300003, 1'b1, 4'b0000, 1'b1, 4'b0011,
               {23'd0, 23'd0, 23'h100002, 23'h000001}, 8'd0};
    tbl[3] = '{23'h500000, 1'b1, 4'b0000, 1'b1, 4'b1011,
               {23'h300003, 23'd0, 23'h100002, 23'h000001}, 8'd0};
    tbl[4] = '{23'h000000, 1'b0, 4'b1111, 1'b1, 4'b1011,
               {23'h300003, 23'd0, 23'h100002, 23'h000001}, 8'd1};
    tbl[5] = '{23'h000000, 1'b0, 4'b0000, 1'b1, 4'b0000, 92'd0, 8'd1};

    // reset state
    uc_in       = 23'h000123;
    uc_in_valid = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_ready", 96'(uc_in_ready), 96'd0);
    chk("rst_m_valid", 96'(uc_in_m_valid), 96'd0);
    chk("rst_m_data", 96'(uc_in_m), 96'd0);
    chk("rst_drop", 96'(drop_cnt), 96'd0);
    uc_in_valid = 1'b0;
    @(negedge aclk);
    reset_n = 1'b1;

    // vector table: unicast to ports 0,1,3 plus one unmapped word
    for (int k = 0; k < 6; k++) begin
      drive_cycle(tbl[k].w, tbl[k].v, tbl[k].mr);
      if (tbl[k].v) chk($sformatf("tbl%0d_ready", k), 96'(uc_in_ready), 96'(tbl[k].exp_rdy));
      chk($sformatf("tbl%0d_m_valid", k), 96'(uc_in_m_valid), 96'(tbl[k].exp_vld));
      chk($sformatf("tbl%0d_m_data", k), 96'(uc_in_m), 96'(tbl[k].exp_m));
      chk($sformatf("tbl%0d_drop", k), 96'(drop_cnt), 96'(tbl[k].exp_drop));
    end

    // five words to a stalled port: fifth waits, pop in the same cycle does not pass it
    got.delete();
    for (int k = 1; k <= 4; k++) drive_cycle(23'h200000 + 23'(k), 1'b1, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(23'h200005, 1'b1, 4'b0000);
      chk("full_stall_ready", 96'(uc_in_ready), 96'd0);
    end
    drive_cycle(23'h200005, 1'b1, 4'b0100);
    chk("full_pop_same_cycle_ready", 96'(uc_in_ready), 96'd0);
    if (uc_in_m_valid[2]) got.push_back(uc_in_m[2*23 +: 23]);
    drive_cycle(23'h200005, 1'b1, 4'b0100);
    chk("after_pop_ready", 96'(uc_in_ready), 96'd1);
    if (uc_in_m_valid[2]) got.push_back(uc_in_m[2*23 +: 23]);
    for (int k = 0; k < 6; k++) begin
      drive_cycle(23'd0, 1'b0, 4'b0100);
      if (uc_in_m_valid[2]) got.push_back(uc_in_m[2*23 +: 23]);
    end
    chk("drain_count", 96'(got.size()), 96'd5);
    for (int k = 0; k < got.size() && k < 5; k++)
      chk($sformatf("drain_order%0d", k), 96'(got[k]), 96'(23'h200000 + 23'(k + 1)));

    // unmapped address flood saturates the drop counter
    for (int k = 0; k < 300; k++) drive_cycle(23'h500000 + 23'(k), 1'b1, 4'b0000);
    drive_cycle(23'd0, 1'b0, 4'b0000);
    chk("drop_saturated", 96'(drop_cnt), 96'd255);
    chk("drop_no_valid", 96'(uc_in_m_valid), 96'd0);

    // simultaneous push and pop on port 0 at occupancy 2
    drive_cycle(23'h0000A0, 1'b1, 4'b0000);
    drive_cycle(23'h0000A1, 1'b1, 4'b0000);
    for (int k = 2; k < 12; k++) drive_cycle(23'h0000A0 + 23'(k), 1'b1, 4'b0001);
    npop = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(23'd0, 1'b0, 4'b0001);
      if (uc_in_m_valid[0]) begin
        chk($sformatf("pushpop_tail%0d", npop), 96'(uc_in_m[22:0]), 96'(23'h0000AA + 23'(npop)));
        npop++;
      end
    end
    chk("pushpop_occupancy", 96'(npop), 96'd2);

    // reset pulse with words queued
    drive_cycle(23'h000011, 1'b1, 4'b0000);
    drive_cycle(23'h100022, 1'b1, 4'b0000);
    drive_cycle(23'h300033, 1'b1, 4'b0000);
    @(negedge aclk);
    uc_in       = 23'h000777;
    uc_in_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_m_valid", 96'(uc_in_m_valid), 96'd0);
    chk("midrst_m_data", 96'(uc_in_m), 96'd0);
    chk("midrst_drop", 96'(drop_cnt), 96'd0);
    chk("midrst_ready", 96'(uc_in_ready), 96'd0);
    for (int i = 0; i < NP; i++) exp_q[i].delete();
    exp_drop = 0;
    @(negedge aclk);
    #1;
    chk("rst_hold_m_valid", 96'(uc_in_m_valid), 96'd0);
    @(negedge aclk);
    reset_n       = 1'b1;
    uc_in         = 23'h000777;
    uc_in_valid   = 1'b1;
    uc_in_m_ready = '0;
    #1;
    model_step();
    drive_cycle(23'd0, 1'b0, 4'b0000);
    chk("post_rst_m_valid", 96'(uc_in_m_valid), 96'd1);
    chk("post_rst_word", 96'(uc_in_m[22:0]), 96'(23'h000777));
    drive_cycle(23'd0, 1'b0, 4'b1111);

`ifdef EPT_IN_BROADCAST_EN
    // broadcast stalls on one full port, then lands on every port
    bw = 23'h70ABCD;
    for (int k = 0; k < 4; k++) drive_cycle(23'h100000 + 23'(k), 1'b1, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(bw, 1'b1, 4'b0000);
      chk("bcast_stall_ready", 96'(uc_in_ready), 96'd0);
    end
    drive_cycle(bw, 1'b1, 4'b0010);
    chk("bcast_pop_same_cycle_ready", 96'(uc_in_ready), 96'd0);
    drive_cycle(bw, 1'b1, 4'b0000);
    chk("bcast_accept_ready", 96'(uc_in_ready), 96'd1);
    drive_cycle(23'd0, 1'b0, 4'b0000);
    for (int i = 0; i < NP; i++)
      if (i != 1) chk($sformatf("bcast_slice%0d", i), 96'(uc_in_m[i*23 +: 23]), 96'(bw));
    chk("bcast_no_drop", 96'(drop_cnt), 96'(exp_drop));
    for (int k = 0; k < 6; k++) drive_cycle(23'd0, 1'b0, 4'b1111);
`else
    bw = 23'h70ABCD;
    drive_cycle(bw, 1'b1, 4'b0000);
    drive_cycle(23'd0, 1'b0, 4'b0000);
    chk("addr7_dropped", 96'(drop_cnt), 96'd1);
    chk("addr7_no_valid", 96'(uc_in_m_valid), 96'd0);
`endif

    // random traffic against the model
    for (int k = 0; k < 600; k++)
      drive_cycle({3'($urandom_range(0, 7)), 20'($urandom)},
                  ($urandom_range(0, 3) != 0), 4'($urandom));
    for (int k = 0; k < 6; k++) drive_cycle(23'd0, 1'b0, 4'b1111);
    chk("final_empty", 96'(uc_in_m_valid), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ept_in_fanout.md
EPT_IN_FANOUT -- requirements
Module: ept_in_fanout

Interface
REQ-001 SHALL have parameter N, default 1, number of user modules fed (legal 1..8).
REQ-002 SHALL have parameter DEPTH, default 4, per-port FIFO depth in words (power of 2, 2..16).
REQ-003 SHALL have port aclk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port uc_in  input  23  library word: [22:20] destination address, [19:0] payload.
REQ-006 SHALL have port uc_in_valid  input  1  uc_in holds a word.
REQ-007 SHALL have port uc_in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have port uc_in_m  output  N*23  per-module word; module i at bits [i*23 +: 23].
REQ-009 SHALL have port uc_in_m_valid  output  N  bit i: uc_in_m slice i holds a word.
REQ-010 SHALL have port uc_in_m_ready  input  N  bit i: module i consumes its word this cycle.
REQ-011 SHALL have port drop_cnt  output  8  count of words dropped for an unmapped address.

Function
REQ-012 SHALL accept a word on a rising edge where uc_in_valid and uc_in_ready are both 1.
REQ-013 SHALL push an accepted word with address a < N into FIFO a unmodified (all 23 bits).
REQ-014 SHALL accept and discard a word with address a >= N; drop_cnt +1, saturating at 255.
REQ-015 SHALL drive uc_in_ready combinationally: 1 when address < N and FIFO[address] not full; 1 when address >= N; 0 during reset.
REQ-016 SHALL not pass through on a full FIFO: uc_in_ready = 0 while target full, even if same-cycle pop.
REQ-017 SHALL present FIFO i head on uc_in_m slice i, uc_in_m_valid[i] = FIFO i not empty.
REQ-018 SHALL pop FIFO i on an edge where uc_in_m_valid[i] and uc_in_m_ready[i] are 1; uc_in_m_ready[i] with valid 0 has no effect.
REQ-019 SHALL give one-cycle latency: word accepted at edge k visible on its port after edge k, valid by edge k+1.
REQ-020 SHALL hold uc_in_m slice and uc_in_m_valid stable while valid=1 and ready=0.
REQ-021 SHALL support simultaneous push and pop on one FIFO (not full): occupancy unchanged, order kept.
REQ-022 SHALL preserve per-port word order; no ordering between ports required.
REQ-023 SHALL keep each FIFO's occupancy counter 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-024 SHALL drive undriven slice bits of an empty FIFO to 0 (no X on uc_in_m).

Reset
REQ-025 SHALL, on reset_n low, asynchronously empty all FIFOs (pointers and counts 0).
REQ-026 SHALL, during reset, drive uc_in_m_valid = 0, uc_in_m = 0, drop_cnt = 0, uc_in_ready = 0.
REQ-027 SHALL discard contents on reset mid-transfer; first accept allowed on first edge after release.

Configuration
REQ-028 SHALL compile a broadcast mode when macro EPT_IN_BROADCAST_EN is defined.
REQ-029 SHALL, with EPT_IN_BROADCAST_EN, treat address 3'b111 as broadcast: push to all N FIFOs in one cycle; uc_in_ready = 1 only when all N FIFOs non-full; never counted as drop.
REQ-030 SHALL, with EPT_IN_BROADCAST_EN and N=8, make port 7 unreachable by unicast.
REQ-031 SHALL, without EPT_IN_BROADCAST_EN, treat address 7 as ordinary unicast (drop if N<=7).

Verification
REQ-032 SHALL cover N=4: words 0x0_00001, 0x1_00002, 0x3_00003 (addr_payload) -> each on its slice one cycle later, other valids 0.
REQ-033 SHALL cover N=4, DEPTH=4, uc_in_m_ready[2]=0: five words to addr 2 -> four accepted, uc_in_ready=0 on fifth until one pop, order 1..5 on drain.
REQ-034 SHALL cover N=2: 300 words to addr 5 -> all accepted, drop_cnt = 255, no uc_in_m_valid.
REQ-035 SHALL cover simultaneous push/pop on port 0 at occupancy 2 for 10 cycles -> occupancy stays 2, data in order.
REQ-036 SHALL cover reset_n pulsed low with 3 words queued -> all valids 0 immediately, drop_cnt 0, no stale word after release.
REQ-037 SHALL cover EPT_IN_BROADCAST_EN, N=3: word 0x7_0ABCD with FIFO 1 full -> stalled; after pop, all three slices show 0x7_0ABCD.
